// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: upstream command stage for the 8-bit accumulator ALU.
// Buffers host commands in a small FIFO and issues them strictly one at a
// time on the ALU operand/selector inputs. It captures the ALU result and the
// multiply-overflow flag, and returns them on a valid/ready result port.
// Optional feature macro: ALU_ERR_COUNT_EN adds a saturating error counter
// output (err_count) that counts accepted results flagged as errors.
module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_acc,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [2:0]       alu_in_sel,
  output logic [6:0]       alu_out_sel,
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             busy
`ifdef ALU_ERR_COUNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [2:0] OP_MULT = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;
  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_LOAD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } stateT;

  stateT state;
  stateT nextState;

  logic [2:0]       fifoOp  [DEPTH];
  logic             fifoAcc [DEPTH];
  logic [WIDTH-1:0] fifoA   [DEPTH];
  logic [WIDTH-1:0] fifoB   [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;
  logic [2:0]       issueOp;
  logic             issueAcc;
  logic [2:0]       headOp;

  assign cmd_ready = (count != FULL_COUNT);
  assign push      = cmd_valid && cmd_ready;
  assign res_valid = (state == ST_DONE);
  assign pop       = (state == ST_IDLE) && (count != '0) && !res_valid;
  assign busy      = (state != ST_IDLE) || (count != '0);
  assign headOp    = fifoOp[rdPtr];

  // Command storage: written on push, read at the head pointer; no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoOp[wrPtr]  <= cmd_op;
      fifoAcc[wrPtr] <= cmd_acc;
      fifoA[wrPtr]   <= cmd_a;
      fifoB[wrPtr]   <= cmd_b;
    end
  end

  // FIFO pointers wrap naturally; occupancy is unchanged on simultaneous push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // On pop the head command is latched and the ALU operands/op select are driven;
  // an illegal opcode leaves the operands alone and clears the output select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issueOp     <= '0;
      issueAcc    <= 1'b0;
      alu_num1    <= '0;
      alu_num2    <= '0;
      alu_out_sel <= '0;
    end else if (pop) begin
      issueOp  <= headOp;
      issueAcc <= fifoAcc[rdPtr];
      if (headOp == OP_ILLEGAL) begin
        alu_out_sel <= '0;
      end else begin
        alu_out_sel <= 7'b1 << headOp;
        alu_num1    <= fifoA[rdPtr];
        alu_num2    <= fifoB[rdPtr];
      end
    end
  end

  // Input mux selects load only while a legal non-accumulating command is in flight.
  always_comb begin
    alu_in_sel = SEL_PERSIST;
    if ((state == ST_ISSUE || state == ST_WAIT) && issueOp != OP_ILLEGAL && !issueAcc) begin
      alu_in_sel = SEL_LOAD;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: illegal opcodes skip the ALU wait cycle.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:  if (pop) nextState = ST_ISSUE;
      ST_ISSUE: nextState = (issueOp == OP_ILLEGAL) ? ST_DONE : ST_WAIT;
      ST_WAIT:  nextState = ST_DONE;
      ST_DONE:  if (res_ready) nextState = ST_IDLE;
      default:  nextState = ST_IDLE;
    endcase
  end

  // Result capture: the ALU register settles at the end of ISSUE, so sample at the end of WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data <= '0;
      res_err  <= 1'b0;
    end else if (state == ST_ISSUE && issueOp == OP_ILLEGAL) begin
      res_data <= '0;
      res_err  <= 1'b1;
    end else if (state == ST_WAIT) begin
      res_data <= alu_result;
      res_err  <= (issueOp == OP_MULT) && alu_ovf;
    end
  end

`ifdef ALU_ERR_COUNT_EN
  // Count accepted error results, saturating at the top of the range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (res_valid && res_ready && res_err && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: a table of single-command vectors checked
// against hand-computed results, plus hand-written burst and mid-flight
// reset sequences. Contains a simple accumulator-ALU environment model.
module tb_alu_cmd_sequencer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = '0;
  logic             cmd_acc = 1'b0;
  logic [WIDTH-1:0] cmd_a = '0;
  logic [WIDTH-1:0] cmd_b = '0;
  logic [2:0]       alu_in_sel;
  logic [6:0]       alu_out_sel;
  logic [WIDTH-1:0] alu_num1;
  logic [WIDTH-1:0] alu_num2;
  logic [WIDTH-1:0] aluResult;
  logic             aluOvf;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_data;
  logic             res_err;
  logic             busy;
`ifdef ALU_ERR_COUNT_EN
  logic [7:0]       errCount;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0]  aluAcc = 8'h00;
  logic [7:0]  opA;
  logic [15:0] product;

  typedef struct {
    logic [2:0] op;
    logic       acc;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] accIn;
    logic [2:0] inSel;
    logic [6:0] outSel;
    logic [7:0] data;
    logic       err;
    int         lat;
  } vecT;

  vecT vecs [12];

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_acc(cmd_acc),
    .cmd_a(cmd_a),
    .cmd_b(cmd_b),
    .alu_in_sel(alu_in_sel),
    .alu_out_sel(alu_out_sel),
    .alu_num1(alu_num1),
    .alu_num2(alu_num2),
    .alu_result(aluResult),
    .alu_ovf(aluOvf),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_err(res_err),
    .busy(busy)
`ifdef ALU_ERR_COUNT_EN
    ,
    .err_count(errCount)
`endif
  );

  always #5 clk = ~clk;

  // ALU environment model: operand A comes from the load path or the ALU's held register
  // (aluAcc, set by the bench); the multiplier flag is produced whatever op is selected.
  always_comb begin
    opA = (alu_in_sel == 3'b010) ? alu_num1 : aluAcc;
    product = opA * alu_num2;
    aluOvf = (product[15:8] != 8'h00);
    case (alu_out_sel)
      7'h01:   aluResult = opA & alu_num2;
      7'h02:   aluResult = opA | alu_num2;
      7'h04:   aluResult = ~opA;
      7'h08:   aluResult = opA ^ alu_num2;
      7'h10:   aluResult = opA + alu_num2;
      7'h20:   aluResult = opA - alu_num2;
      7'h40:   aluResult = product[7:0];
      default: aluResult = 8'h00;
    endcase
  end

  // Compare one value and report a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Offer one command for a single cycle, starting and ending on a falling edge.
  task automatic applyStimulus(input logic [2:0] op, input logic acc, input logic [7:0] a, input logic [7:0] b);
    cmd_op = op;
    cmd_acc = acc;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) until the sequencer drains.
  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s idle timeout busy=%0d expected=0", tag, busy);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int expErrCount;
    int n;
    logic sawValid;

    vecs[0]  = '{3'd4, 1'b0, 8'h05, 8'h03, 8'h00, 3'b010, 7'h10, 8'h08, 1'b0, 2};
    vecs[1]  = '{3'd6, 1'b0, 8'h20, 8'h10, 8'h00, 3'b010, 7'h40, 8'h00, 1'b1, 2};
    vecs[2]  = '{3'd7, 1'b0, 8'h12, 8'h34, 8'h00, 3'b100, 7'h00, 8'h00, 1'b1, 1};
    vecs[3]  = '{3'd4, 1'b1, 8'h00, 8'h01, 8'h08, 3'b100, 7'h10, 8'h09, 1'b0, 2};
    vecs[4]  = '{3'd5, 1'b0, 8'h03, 8'h05, 8'h00, 3'b010, 7'h20, 8'hFE, 1'b0, 2};
    vecs[5]  = '{3'd0, 1'b0, 8'hF0, 8'h3C, 8'h00, 3'b010, 7'h01, 8'h30, 1'b0, 2};
    vecs[6]  = '{3'd1, 1'b0, 8'hF0, 8'h0C, 8'h00, 3'b010, 7'h02, 8'hFC, 1'b0, 2};
    vecs[7]  = '{3'd2, 1'b0, 8'h0F, 8'h00, 8'h00, 3'b010, 7'h04, 8'hF0, 1'b0, 2};
    vecs[8]  = '{3'd3, 1'b0, 8'hAA, 8'hFF, 8'h00, 3'b010, 7'h08, 8'h55, 1'b0, 2};
    vecs[9]  = '{3'd6, 1'b0, 8'h0F, 8'h11, 8'h00, 3'b010, 7'h40, 8'hFF, 1'b0, 2};
    vecs[10] = '{3'd4, 1'b0, 8'hFF, 8'h02, 8'h00, 3'b010, 7'h10, 8'h01, 1'b0, 2};
    vecs[11] = '{3'd6, 1'b1, 8'h00, 8'h03, 8'h05, 3'b100, 7'h40, 8'h0F, 1'b0, 2};

    repeat (2) @(negedge clk);
    checkOutput("rst.res_valid", res_valid, 1'b0);
    checkOutput("rst.res_data", res_data, 8'h00);
    checkOutput("rst.res_err", res_err, 1'b0);
    checkOutput("rst.in_sel", alu_in_sel, 3'b100);
    checkOutput("rst.out_sel", alu_out_sel, 7'h00);
    checkOutput("rst.num1", alu_num1, 8'h00);
    checkOutput("rst.num2", alu_num2, 8'h00);
    checkOutput("rst.cmd_ready", cmd_ready, 1'b1);
    checkOutput("rst.busy", busy, 1'b0);
`ifdef ALU_ERR_COUNT_EN
    checkOutput("rst.err_count", errCount, 8'h00);
`endif
    rst = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);

    expErrCount = 0;
    for (int i = 0; i < 12; i++) begin
      waitIdle($sformatf("v%0d", i));
      aluAcc = vecs[i].accIn;
      applyStimulus(vecs[i].op, vecs[i].acc, vecs[i].a, vecs[i].b);
      @(negedge clk);
      checkOutput($sformatf("v%0d.in_sel", i), alu_in_sel, vecs[i].inSel);
      checkOutput($sformatf("v%0d.out_sel", i), alu_out_sel, vecs[i].outSel);
      if (vecs[i].op != 3'd7) begin
        checkOutput($sformatf("v%0d.num1", i), alu_num1, vecs[i].a);
        checkOutput($sformatf("v%0d.num2", i), alu_num2, vecs[i].b);
      end
      n = 0;
      while (!res_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      checkOutput($sformatf("v%0d.latency", i), n, vecs[i].lat);
      checkOutput($sformatf("v%0d.res_data", i), res_data, vecs[i].data);
      checkOutput($sformatf("v%0d.res_err", i), res_err, vecs[i].err);
      if (vecs[i].err) expErrCount++;
      @(negedge clk);
      checkOutput($sformatf("v%0d.res_valid_drop", i), res_valid, 1'b0);
    end
`ifdef ALU_ERR_COUNT_EN
    checkOutput("err_count", errCount, expErrCount);
`endif

    // Burst of five commands with the consumer stalled: one in flight, four queued.
    waitIdle("burst");
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(3'd4, 1'b0, 8'h10 + 8'(k), 8'(k));
    end
    checkOutput("burst.cmd_ready_full", cmd_ready, 1'b0);
    checkOutput("burst.busy", busy, 1'b1);
    checkOutput("burst.res_valid_held", res_valid, 1'b1);
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!res_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      checkOutput($sformatf("burst%0d.res_valid", k), res_valid, 1'b1);
      checkOutput($sformatf("burst%0d.res_data", k), res_data, 8'h10 + 8'(2 * k));
      checkOutput($sformatf("burst%0d.res_err", k), res_err, 1'b0);
      @(negedge clk);
      if (k == 0) begin
        checkOutput("burst.cmd_ready_before_pop", cmd_ready, 1'b0);
        @(negedge clk);
        checkOutput("burst.cmd_ready_after_pop", cmd_ready, 1'b1);
      end
    end

    // Reset asserted while a command sits in WAIT with two more queued.
    waitIdle("midreset");
    res_ready = 1'b0;
    applyStimulus(3'd4, 1'b0, 8'h21, 8'h01);
    applyStimulus(3'd4, 1'b0, 8'h31, 8'h01);
    applyStimulus(3'd4, 1'b0, 8'h41, 8'h01);
    checkOutput("midreset.in_sel_wait", alu_in_sel, 3'b010);
    rst = 1'b1;
    #1;
    checkOutput("midreset.res_valid", res_valid, 1'b0);
    checkOutput("midreset.in_sel", alu_in_sel, 3'b100);
    checkOutput("midreset.out_sel", alu_out_sel, 7'h00);
    checkOutput("midreset.num1", alu_num1, 8'h00);
    checkOutput("midreset.num2", alu_num2, 8'h00);
    checkOutput("midreset.res_data", res_data, 8'h00);
    checkOutput("midreset.cmd_ready", cmd_ready, 1'b1);
    checkOutput("midreset.busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    sawValid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      sawValid = sawValid | res_valid;
    end
    checkOutput("midreset.no_result", sawValid, 1'b0);
    checkOutput("midreset.queue_lost", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
